// File: rtl/msg_pagealign_pipe_pkg.sv
// Shared definitions for the page-alignment pipeline: mode encoding,
// shift-width derivation and lane slicing helper.
package msg_pagealign_pipe_pkg;

    localparam logic MODE_BYPASS = 1'b0;
    localparam logic MODE_ACC    = 1'b1;

    function automatic int unsigned shift_w_of(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned qsize);
        return lane * qsize;
    endfunction

endpackage

// File: rtl/msg_pagealign_pipe_circ_rotator.sv
// Combinational circular lane rotator: out lane j = in lane (j + shift) mod LANES,
// built as log2 mux stages each rotating by a power of two.
module msg_pagealign_pipe_circ_rotator
    import msg_pagealign_pipe_pkg::*;
#(
    parameter int unsigned LANES = 5,
    parameter int unsigned QSIZE = 4,
    parameter int unsigned SW    = shift_w_of(LANES)
) (
    input  logic [LANES*QSIZE-1:0] i_data,
    input  logic [SW-1:0]          i_shift,
    output logic [LANES*QSIZE-1:0] o_data_c
);

    localparam int unsigned W = LANES * QSIZE;

    // Stage b rotates by 2^b lanes when shift bit b is set; stages compose additively.
    always_comb begin
        logic [W-1:0] w_cur;
        logic [W-1:0] w_prev;
        w_cur  = i_data;
        w_prev = i_data;
        for (int b = 0; b < int'(SW); b++) begin
            w_prev = w_cur;
            if (i_shift[b]) begin
                for (int j = 0; j < int'(LANES); j++) begin
                    w_cur[lane_lsb(j, QSIZE) +: QSIZE] =
                        w_prev[lane_lsb((j + (1 << b)) % LANES, QSIZE) +: QSIZE];
                end
            end
        end
        o_data_c = w_cur;
    end

endmodule

// File: rtl/msg_pagealign_pipe.sv
// Two-stage page-alignment pipeline: S1 rotates each beat, S2 merges rotated
// lanes into a page buffer (accumulate) or forwards the beat as a page (bypass).
module msg_pagealign_pipe
    import msg_pagealign_pipe_pkg::*;
#(
    parameter int unsigned SHIFT_LENGTH = 5,
    parameter int unsigned QUAN_SIZE    = 4,
    parameter int unsigned L2PA_ENABLE  = 1,
    parameter int unsigned SHIFT_W      = shift_w_of(SHIFT_LENGTH)
) (
    input  logic                              sys_clk,
    input  logic                              rst,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [SHIFT_LENGTH*QUAN_SIZE-1:0] in_msg_i,
    input  logic [SHIFT_W-1:0]                shift_factor_i,
    input  logic [SHIFT_LENGTH-1:0]           load_mask_i,
    input  logic                              is_msg_pass_i,
    input  logic                              last_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [SHIFT_LENGTH*QUAN_SIZE-1:0] out_msg_o,
    output logic [SHIFT_LENGTH-1:0]           out_mask_o,
    output logic                              shift_err_o
);

    localparam int unsigned MSG_W = SHIFT_LENGTH * QUAN_SIZE;

    logic                    w_en;
    logic                    w_accept;
    logic                    w_shift_ok;
    logic                    w_s2_fire;
    logic [SHIFT_W-1:0]      w_shift_eff;
    logic [MSG_W-1:0]        w_rot;
    logic [MSG_W-1:0]        w_merged;
    logic [SHIFT_LENGTH-1:0] w_m;

    logic                    r_s1_valid;
    logic [MSG_W-1:0]        r_s1_data;
    logic [SHIFT_LENGTH-1:0] r_s1_mask;
    logic                    r_s1_mode;
    logic                    r_s1_last;
    logic [MSG_W-1:0]        r_buf;
    logic [SHIFT_LENGTH-1:0] r_acc_mask;

    // Whole pipeline advances unless a page is held against a stalled consumer.
    assign w_en        = !(out_valid_o && !out_ready_i);
    assign in_ready_o  = rst || w_en;
    assign w_accept    = in_valid_i && w_en;
    assign w_shift_ok  = 32'(shift_factor_i) < SHIFT_LENGTH;
    assign w_shift_eff = w_shift_ok ? shift_factor_i : '0;
    assign w_s2_fire   = w_en && r_s1_valid;
    assign w_m         = (L2PA_ENABLE != 0) ? r_s1_mask : '0;

    msg_pagealign_pipe_circ_rotator #(
        .LANES (SHIFT_LENGTH),
        .QSIZE (QUAN_SIZE),
        .SW    (SHIFT_W)
    ) u_rot (
        .i_data   (in_msg_i),
        .i_shift  (w_shift_eff),
        .o_data_c (w_rot)
    );

    // Page buffer with the current S2 beat overlaid on its masked lanes.
    always_comb begin
        w_merged = r_buf;
        for (int j = 0; j < int'(SHIFT_LENGTH); j++) begin
            if (w_m[j]) begin
                w_merged[lane_lsb(j, QUAN_SIZE) +: QUAN_SIZE] =
                    r_s1_data[lane_lsb(j, QUAN_SIZE) +: QUAN_SIZE];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mask  <= '0;
            r_s1_mode  <= MODE_BYPASS;
            r_s1_last  <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid_i;
            r_s1_data  <= w_rot;
            r_s1_mask  <= load_mask_i;
            r_s1_mode  <= is_msg_pass_i;
            r_s1_last  <= last_i;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            shift_err_o <= 1'b0;
        end else if (w_accept && !w_shift_ok) begin
            shift_err_o <= 1'b1;
        end
    end

    // A new emit in the same cycle as a consume overrides the valid clear.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            out_msg_o   <= '0;
            out_mask_o  <= '0;
            r_buf       <= '0;
            r_acc_mask  <= '0;
        end else begin
            if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            if (w_s2_fire) begin
                if (r_s1_mode == MODE_BYPASS) begin
                    out_msg_o   <= r_s1_data;
                    out_mask_o  <= '1;
                    out_valid_o <= 1'b1;
                end else if (r_s1_last) begin
                    out_msg_o   <= w_merged;
                    out_mask_o  <= r_acc_mask | w_m;
                    out_valid_o <= 1'b1;
                    r_buf       <= '0;
                    r_acc_mask  <= '0;
                end else begin
                    r_buf      <= w_merged;
                    r_acc_mask <= r_acc_mask | w_m;
                end
            end
        end
    end

endmodule
